// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and
// assembles complete in-order 8-digit scans into 32-bit frames.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [7:0]  anode_in,
  input  logic [6:0]  cathode_in,
  output logic [31:0] digits_out,
  output logic [7:0]  digit_valid_out,
  output logic [31:0] frame_out,
  output logic        frame_valid_out,
  output logic        bad_pattern_out,
  output logic        multi_anode_out
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {SEEK, COLLECT} state_t;

  logic [14:0]   s;
  logic [14:0]   s_prev;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [2:0]    exp_idx;

  logic [7:0] anode_low;
  logic [7:0] prev_low;
  logic       one_low;
  logic       multi_now;
  logic       multi_prev;
  logic [2:0] idx;
  logic       hex_ok;
  logic [3:0] hex_val;
  logic       blank;
  logic       stable;
  logic       capture;

  always_comb begin
    anode_low  = ~s[14:7];
    prev_low   = ~s_prev[14:7];
    // x & (x-1) clears the lowest set bit: zero result means at most one bit set
    one_low    = (anode_low != '0) && ((anode_low & (anode_low - 8'd1)) == '0);
    multi_now  = (anode_low & (anode_low - 8'd1)) != '0;
    multi_prev = (prev_low & (prev_low - 8'd1)) != '0;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (anode_low[i]) idx = i[2:0];
    end
    hex_ok  = 1'b1;
    hex_val = '0;
    case (s[6:0])
      7'b1000000: hex_val = 4'h0;
      7'b1111001: hex_val = 4'h1;
      7'b0100100: hex_val = 4'h2;
      7'b0110000: hex_val = 4'h3;
      7'b0011001: hex_val = 4'h4;
      7'b0010010: hex_val = 4'h5;
      7'b0000010: hex_val = 4'h6;
      7'b1111000: hex_val = 4'h7;
      7'b0000000: hex_val = 4'h8;
      7'b0010000: hex_val = 4'h9;
      7'b0001000: hex_val = 4'hA;
      7'b0000011: hex_val = 4'hB;
      7'b1000110: hex_val = 4'hC;
      7'b0100001: hex_val = 4'hD;
      7'b0000110: hex_val = 4'hE;
      7'b0001110: hex_val = 4'hF;
      default:    hex_ok  = 1'b0;
    endcase
    blank   = (s[6:0] == 7'h7F);
    stable  = one_low && (s == s_prev);
    capture = stable && (cnt == CW'(STABLE_CYCLES - 1));
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      s               <= '1;
      s_prev          <= '1;
      cnt             <= CW'(1);
      digits_out      <= '0;
      digit_valid_out <= '0;
      frame_out       <= '0;
      frame_valid_out <= 1'b0;
      bad_pattern_out <= 1'b0;
      multi_anode_out <= 1'b0;
      state           <= SEEK;
      exp_idx         <= '0;
    end else begin
      s               <= {anode_in, cathode_in};
      s_prev          <= s;
      frame_valid_out <= 1'b0;
      bad_pattern_out <= 1'b0;
      multi_anode_out <= multi_now && !multi_prev;

      if (!stable)
        cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + CW'(1);

      if (capture) begin
        if (hex_ok) begin
          digits_out[{idx, 2'b00} +: 4] <= hex_val;
          digit_valid_out[idx]          <= 1'b1;
        end else begin
          digit_valid_out[idx] <= 1'b0;
          bad_pattern_out      <= !blank;
        end
      end

      // Only captures move the frame tracker; idle/multi samples leave it alone
      case (state)
        SEEK: begin
          if (capture && hex_ok && idx == 3'd0) begin
            state   <= COLLECT;
            exp_idx <= 3'd1;
          end
        end
        COLLECT: begin
          if (capture) begin
            if (hex_ok && idx == 3'd0) begin
              exp_idx <= 3'd1;
            end else if (hex_ok && idx == exp_idx) begin
              if (exp_idx == 3'd7) begin
                frame_out       <= {hex_val, digits_out[27:0]};
                frame_valid_out <= 1'b1;
                state           <= SEEK;
                exp_idx         <= '0;
              end else begin
                exp_idx <= exp_idx + 3'd1;
              end
            end else begin
              state   <= SEEK;
              exp_idx <= '0;
            end
          end
        end
        default: begin
          state   <= SEEK;
          exp_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: timing sequences plus a table of
// 6-cycle digit dwells with expected digits, valids, frame and pulse counts.
module tb_seven_seg_scan_decoder;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [7:0]  anode_in = 8'hFF;
  logic [6:0]  cathode_in = 7'h7F;
  logic [31:0] digits_out;
  logic [7:0]  digit_valid_out;
  logic [31:0] frame_out;
  logic        frame_valid_out;
  logic        bad_pattern_out;
  logic        multi_anode_out;

  seven_seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clock_in        (clock_in),
    .reset_in        (reset_in),
    .anode_in        (anode_in),
    .cathode_in      (cathode_in),
    .digits_out      (digits_out),
    .digit_valid_out (digit_valid_out),
    .frame_out       (frame_out),
    .frame_valid_out (frame_valid_out),
    .bad_pattern_out (bad_pattern_out),
    .multi_anode_out (multi_anode_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  ca;
    logic [31:0] dig;
    logic [7:0]  vld;
    logic [31:0] frm;
    int          fp;
    int          bp;
    int          mp;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  int fpc, bpc, mpc;

  localparam logic [6:0] BAD   = 7'b1010101;
  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] seg(input int v);
    case (v)
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [7:0] an_of(input int n);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << n);
  endfunction

  task automatic add(input logic [7:0] an, input logic [6:0] ca, input logic [31:0] dig,
                     input logic [7:0] vld, input logic [31:0] frm, input int fp,
                     input int bp, input int mp);
    vec_t v;
    v.an = an; v.ca = ca; v.dig = dig; v.vld = vld; v.frm = frm;
    v.fp = fp; v.bp = bp; v.mp = mp;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock_in);
      #1;
      fpc += int'(frame_valid_out);
      bpc += int'(bad_pattern_out);
      mpc += int'(multi_anode_out);
    end
  endtask

  task automatic clr_counts();
    fpc = 0; bpc = 0; mpc = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_digits"}, digits_out, 32'h0);
    chk({nm, "_valid"}, {24'h0, digit_valid_out}, 32'h0);
    chk({nm, "_frame"}, frame_out, 32'h0);
    chk({nm, "_pulses"}, {29'h0, frame_valid_out, bad_pattern_out, multi_anode_out}, 32'h0);
  endtask

  initial begin
    // Reset held with random bus activity
    clr_counts();
    for (int k = 0; k < 6; k++) begin
      anode_in   = 8'($urandom);
      cathode_in = 7'($urandom);
      run(1);
    end
    chk_all_zero("in_reset");
    anode_in = 8'hFF; cathode_in = BLANK;
    reset_in = 1'b1;
    clr_counts();
    run(10);
    chk_all_zero("idle_after_reset");
    chk("idle_pulse_count", fpc + bpc + mpc, 0);

    // Single capture: update at edge E+4, not before
    anode_in = 8'hFE; cathode_in = seg(2);
    run(4);
    chk("cap_early_valid", {24'h0, digit_valid_out}, 32'h0);
    chk("cap_early_digits", digits_out, 32'h0);
    run(1);
    chk("cap_digits", digits_out, 32'h2);
    chk("cap_valid", {24'h0, digit_valid_out}, 32'h01);
    anode_in = 8'hFF; cathode_in = BLANK;
    run(6);

    // Dwell of only 3 samples is discarded
    clr_counts();
    anode_in = 8'hFD; cathode_in = seg(1);
    run(3);
    anode_in = 8'hFF; cathode_in = BLANK;
    run(8);
    chk("short_digits", digits_out, 32'h2);
    chk("short_valid", {24'h0, digit_valid_out}, 32'h01);
    chk("short_pulses", fpc + bpc + mpc, 0);

    // Full frame 1..8
    add(an_of(0), seg(1), 32'h00000001, 8'h01, 32'h0, 0, 0, 0);
    add(an_of(1), seg(2), 32'h00000021, 8'h03, 32'h0, 0, 0, 0);
    add(an_of(2), seg(3), 32'h00000321, 8'h07, 32'h0, 0, 0, 0);
    add(an_of(3), seg(4), 32'h00004321, 8'h0F, 32'h0, 0, 0, 0);
    add(an_of(4), seg(5), 32'h00054321, 8'h1F, 32'h0, 0, 0, 0);
    add(an_of(5), seg(6), 32'h00654321, 8'h3F, 32'h0, 0, 0, 0);
    add(an_of(6), seg(7), 32'h07654321, 8'h7F, 32'h0, 0, 0, 0);
    add(an_of(7), seg(8), 32'h87654321, 8'hFF, 32'h87654321, 1, 0, 0);
    // Repeat scan
    for (int n = 0; n < 8; n++)
      add(an_of(n), seg(n + 1), 32'h87654321, 8'hFF, 32'h87654321, (n == 7) ? 1 : 0, 0, 0);
    // Out of order: 0,1,2,5 aborts; continuing 3..7 must not complete a frame
    add(an_of(0), seg(1), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(1), seg(2), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(2), seg(3), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(5), seg(9), 32'h87954321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(3), seg(4), 32'h87954321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(4), seg(5), 32'h87954321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(5), seg(6), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(6), seg(7), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(7), seg(8), 32'h87654321, 8'hFF, 32'h87654321, 0, 0, 0);
    // Fresh scan showing 8..1
    add(an_of(0), seg(8), 32'h87654328, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(1), seg(7), 32'h87654378, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(2), seg(6), 32'h87654678, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(3), seg(5), 32'h87655678, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(4), seg(4), 32'h87645678, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(5), seg(3), 32'h87345678, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(6), seg(2), 32'h82345678, 8'hFF, 32'h87654321, 0, 0, 0);
    add(an_of(7), seg(1), 32'h12345678, 8'hFF, 32'h12345678, 1, 0, 0);
    // Bad pattern on digit 3 aborts the frame
    for (int n = 0; n < 3; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(an_of(3), BAD, 32'h12345678, 8'hF7, 32'h12345678, 0, 1, 0);
    for (int n = 3; n < 8; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    // Blank on digit 4 clears its valid, keeps its nibble, aborts the frame
    for (int n = 0; n < 4; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(an_of(4), BLANK, 32'h12345678, 8'hEF, 32'h12345678, 0, 0, 0);
    for (int n = 4; n < 8; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    // Multi-anode: one pulse on entry only, no capture
    add(8'hFC, seg(8), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 1);
    add(8'hF0, seg(8), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(8'hFF, BLANK, 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    // Multi-anode and idle in the middle of a frame do not abort it
    add(an_of(0), seg(8), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(an_of(1), seg(7), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(8'hFC, seg(8), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 1);
    add(8'hFF, BLANK, 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    for (int n = 2; n < 8; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, (n == 7) ? 1 : 0, 0, 0);
    // Digit 0 mid-frame restarts collection
    add(an_of(0), seg(8), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    add(an_of(1), seg(7), 32'h12345678, 8'hFF, 32'h12345678, 0, 0, 0);
    for (int n = 0; n < 8; n++)
      add(an_of(n), seg(8 - n), 32'h12345678, 8'hFF, 32'h12345678, (n == 7) ? 1 : 0, 0, 0);

    foreach (vq[i]) begin
      clr_counts();
      anode_in   = vq[i].an;
      cathode_in = vq[i].ca;
      run(6);
      chk($sformatf("v%0d_digits", i), digits_out, vq[i].dig);
      chk($sformatf("v%0d_valid", i), {24'h0, digit_valid_out}, {24'h0, vq[i].vld});
      chk($sformatf("v%0d_frame", i), frame_out, vq[i].frm);
      chk($sformatf("v%0d_frame_pulses", i), fpc, vq[i].fp);
      chk($sformatf("v%0d_bad_pulses", i), bpc, vq[i].bp);
      chk($sformatf("v%0d_multi_pulses", i), mpc, vq[i].mp);
    end

    // Reset in the middle of a frame clears immediately; next frame restarts at digit 0
    for (int n = 0; n < 4; n++) begin
      anode_in = an_of(n); cathode_in = seg(8 - n);
      run(6);
    end
    reset_in = 1'b0;
    #2;
    chk_all_zero("midreset");
    anode_in = 8'hFF; cathode_in = BLANK;
    run(2);
    reset_in = 1'b1;
    clr_counts();
    for (int n = 4; n < 8; n++) begin
      anode_in = an_of(n); cathode_in = seg(8 - n);
      run(6);
    end
    chk("post_reset_digits", digits_out, 32'h12340000);
    chk("post_reset_valid", {24'h0, digit_valid_out}, 32'hF0);
    chk("post_reset_frame", frame_out, 32'h0);
    chk("post_reset_frame_pulses", fpc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart of the seven-segment driver path. It watches a multiplexed, active-low anode/cathode display bus and recovers the hex value being shown on each digit. It then assembles complete 8-digit scan frames into a 32-bit word. It sits between the display pins (or a loopback of the driver outputs) and the self-check / readback logic.

## Interface
- STABLE_CYCLES, default 4: consecutive identical registered bus samples required before a digit is captured. Minimum 2.
- clock_in  input  1  system clock; all state on its rising edge
- reset_in  input  1  asynchronous, active-low reset
- anode_in  input  8  digit enables, active-low; bit n = digit n (digit 0 = least significant nibble)
- cathode_in  input  7  segments g..a (bit6 = g), active-low
- digits_out  output  32  live decoded value; nibble n = digit n
- digit_valid_out  output  8  bit n set when nibble n holds a decoded hex value
- frame_out  output  32  snapshot of digits 0..7 from the last complete in-order scan
- frame_valid_out  output  1  one-cycle pulse when frame_out updates
- bad_pattern_out  output  1  one-cycle pulse when a capture sees a non-hex, non-blank pattern
- multi_anode_out  output  1  one-cycle pulse on the first sample with more than one anode low

## Operation
- Sample stage: {anode_in, cathode_in} is registered every edge into s. The previous sample is kept in s_prev.
- Eligible sample: exactly one anode bit low.
- Not eligible, all anodes high: idle, no error.
- Not eligible, more than one anode low: multi_anode_out pulses on the first such cycle only (the previous sample was not multi-low).
- Stability counter cnt:
  - Reset to 1 whenever s differs from s_prev or s is ineligible.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture: occurs in the cycle cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES. There is exactly one capture per dwell, with no re-capture while the sample is held.
- Decode table (cathode g..a -> hex):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=B, 1000110=C, 0100001=D, 0000110=E, 0001110=F
- Capture on digit n:
  - Hex pattern: nibble n <= value, digit_valid_out[n] <= 1.
  - 1111111 (blank): nibble n unchanged, digit_valid_out[n] <= 0, no error.
  - Any other pattern: nibble n unchanged, digit_valid_out[n] <= 0, bad_pattern_out pulses.
- Frame FSM, states SEEK and COLLECT with a 3-bit expected index exp:
  - SEEK: a valid hex capture on digit 0 -> COLLECT, exp <= 1. Everything else stays in SEEK.
  - COLLECT, valid hex capture on digit exp, exp < 7: exp <= exp+1.
  - COLLECT, valid hex capture on digit 7 with exp = 7: frame_out <= digits_out including this capture, frame_valid_out pulses, -> SEEK.
  - COLLECT, valid hex capture on digit 0 when exp != 0: restart the frame, exp <= 1, stay in COLLECT.
  - COLLECT, any other capture (wrong digit, blank, bad pattern): -> SEEK.
  - Ineligible samples and multi-anode samples do not change FSM state. Only captures advance or abort a frame.

## Timing
- Reset (reset_in low, asynchronous):
  - digits_out, digit_valid_out, frame_out = 0.
  - All pulses = 0.
  - s and s_prev = all-ones (idle bus), cnt = 1, FSM = SEEK, exp = 0.
- Pins held constant from before edge E:
  - s updates at E.
  - Capture decision is made in the cycle after edge E+STABLE_CYCLES-1.
  - digits_out, digit_valid_out and bad_pattern_out update at edge E+STABLE_CYCLES.
- frame_out and frame_valid_out update on the same edge as the digit-7 capture. The pulse is high for exactly one cycle.
- A bus change before cnt reaches STABLE_CYCLES discards the dwell: no capture, no error.
- Reset asserted mid-frame clears all state immediately. The first frame after release must start again from digit 0.
- Glitches shorter than STABLE_CYCLES samples have no effect on any output except multi_anode_out.

## Test plan
- Reset values: drive reset_in low with random bus activity -> all outputs 0. After release with the bus idle (anodes 8'hFF) -> outputs stay 0.
- Single capture: anode 8'hFE, cathode 7'b0100100, held 4 cycles (STABLE_CYCLES=4) -> digits_out[3:0]=2 and digit_valid_out=8'h01 at edge E+4, no earlier. Held 3 cycles then changed -> no update.
- Full frame: scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 6 cycles -> frame_out=32'h87654321 with a single frame_valid_out pulse. Repeat the scan -> second pulse, same value.
- Out of order: digits 0,1,2 then digit 5 -> FSM returns to SEEK, no frame pulse. Then digits 0..7 -> frame_valid_out pulses.
- Errors:
  - Cathode 7'b1010101 held on digit 3 -> one bad_pattern_out pulse, digit_valid_out[3]=0, frame aborted.
  - Anode 8'hFC -> one multi_anode_out pulse, no capture.
- Blank: cathode 7'b1111111 on digit 4 -> digit_valid_out[4] clears, nibble 4 keeps its old value, no bad_pattern_out, frame aborted.
